// File: rtl/vu_bar_meter.sv
// VU-meter LED bar driven by received UART bytes: instant attack, linear decay.
// Optional peak-hold marker built when VU_PEAK_HOLD_EN is defined.
module vu_bar_meter #(
    parameter int LEDS        = 8,
    parameter int DECAY_DIV   = 1024,
    parameter int HOLD_CYCLES = 65536
) (
    input  logic            clk_board,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      data,
    input  logic            load,
    input  logic            error,
    output logic [LEDS-1:0] bar,
    output logic [LEDS-1:0] peak_led,
    output logic [7:0]      drops
);

    localparam int STEP       = 256 / LEDS;
    localparam int STEP_SHIFT = $clog2(STEP);
    localparam int DW         = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);

    logic [7:0]      level;
    logic [DW-1:0]   decay_cnt;
    logic            accept;
    logic            reject;
    logic            attack;
    logic            decay_wrap;
    logic [LEDS-1:0] bar_next;

    assign accept     = load & ~error & enable;
    assign reject     = load & error & enable;
    assign attack     = accept && (data >= level);
    assign decay_wrap = (decay_cnt == DECAY_LAST);

    // Attack takes priority over a coincident decay tick and restarts the decay period.
    always_ff @(posedge clk_board) begin
        if (reset) begin
            level     <= '0;
            decay_cnt <= '0;
        end else if (enable) begin
            if (attack) begin
                level     <= data;
                decay_cnt <= '0;
            end else begin
                decay_cnt <= decay_wrap ? '0 : decay_cnt + DW'(1);
                if (decay_wrap && (level != '0))
                    level <= level - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_board) begin
        if (reset)
            drops <= '0;
        else if (reject && (drops != '1))
            drops <= drops + 8'd1;
    end

    always_comb begin
        bar_next = '0;
        for (int unsigned i = 0; i < LEDS; i++)
            bar_next[i] = ({1'b0, level} > 9'(i * STEP));
    end

    always_ff @(posedge clk_board) begin
        if (reset)
            bar <= '0;
        else if (enable)
            bar <= bar_next;
    end

`ifdef VU_PEAK_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [7:0]      peak;
    logic [HW-1:0]   hold_cnt;
    logic [7:0]      peak_idx;
    logic [LEDS-1:0] peak_next;

    // Once the hold expires the peak follows the current level down.
    always_ff @(posedge clk_board) begin
        if (reset) begin
            peak     <= '0;
            hold_cnt <= '0;
        end else if (enable) begin
            if (accept && (data >= peak)) begin
                peak     <= data;
                hold_cnt <= HOLD_LAST;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end else begin
                peak <= level;
            end
        end
    end

    always_comb begin
        peak_idx  = (peak - 8'd1) >> STEP_SHIFT;
        peak_next = '0;
        for (int unsigned i = 0; i < LEDS; i++)
            peak_next[i] = (peak != '0) && (peak_idx == 8'(i));
    end

    always_ff @(posedge clk_board) begin
        if (reset)
            peak_led <= '0;
        else if (enable)
            peak_led <= peak_next;
    end
`else
    assign peak_led = '0;
`endif

endmodule

// File: tb/tb_vu_bar_meter.sv
// Scoreboard bench for vu_bar_meter: a behavioural model queues expected outputs per cycle.
module tb_vu_bar_meter;

    localparam int LEDS        = 8;
    localparam int DECAY_DIV   = 4;
    localparam int HOLD_CYCLES = 16;
    localparam int STEP        = 256 / LEDS;
`ifdef VU_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic       clk_board = 1'b0;
    logic       reset, enable, load, error;
    logic [7:0] data;
    logic [7:0] bar, peak_led, drops;

    always #5 clk_board = ~clk_board;

    vu_bar_meter #(
        .LEDS(LEDS),
        .DECAY_DIV(DECAY_DIV),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk_board(clk_board),
        .reset(reset),
        .enable(enable),
        .data(data),
        .load(load),
        .error(error),
        .bar(bar),
        .peak_led(peak_led),
        .drops(drops)
    );

    typedef struct packed {
        logic [7:0] bar;
        logic [7:0] pled;
        logic [7:0] drops;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int         m_level = 0, m_peak = 0, m_dcnt = 0, m_hold = 0, m_drops = 0;
    logic [7:0] m_bar = '0, m_pled = '0;

    // Lit segment count is ceil(level / STEP).
    function automatic logic [7:0] bar_model(input int lvl);
        int n;
        n = (lvl + STEP - 1) / STEP;
        return 8'((1 << n) - 1);
    endfunction

    function automatic logic [7:0] pled_model(input int pk);
        if (!PEAK_EN || pk == 0)
            return 8'h00;
        return 8'(1 << ((pk - 1) / STEP));
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic en, input logic ld,
                              input logic er, input logic [7:0] d);
        int old_level;
        if (r) begin
            m_level = 0; m_peak = 0; m_dcnt = 0; m_hold = 0; m_drops = 0;
            m_bar = '0; m_pled = '0;
        end else if (en) begin
            m_bar     = bar_model(m_level);
            m_pled    = pled_model(m_peak);
            old_level = m_level;
            if (ld && er && m_drops < 255)
                m_drops++;
            if (ld && !er && int'(d) >= m_level) begin
                m_level = int'(d);
                m_dcnt  = 0;
            end else if (m_dcnt == DECAY_DIV - 1) begin
                m_dcnt = 0;
                if (m_level > 0)
                    m_level--;
            end else begin
                m_dcnt++;
            end
            if (ld && !er && int'(d) >= m_peak) begin
                m_peak = int'(d);
                m_hold = HOLD_CYCLES - 1;
            end else if (m_hold > 0) begin
                m_hold--;
            end else begin
                m_peak = old_level;
            end
        end
        sb_q.push_back('{bar: m_bar, pled: m_pled, drops: 8'(m_drops)});
    endtask

    task automatic tick(input logic r, input logic en, input logic ld,
                        input logic er, input logic [7:0] d);
        exp_t e;
        reset = r; enable = en; load = ld; error = er; data = d;
        model_step(r, en, ld, er, d);
        @(posedge clk_board);
        #1;
        load = 1'b0; error = 1'b0; reset = 1'b0;
        e = sb_q.pop_front();
        check("bar", int'(bar), int'(e.bar));
        check("peak_led", int'(peak_led), int'(e.pled));
        check("drops", int'(drops), int'(e.drops));
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int         cnt;
        logic [7:0] hb, hp, hd;
        reset = 1'b1; enable = 1'b1; load = 1'b0; error = 1'b0; data = '0;

        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(100);
        check("rst_bar", int'(bar), 0);
        check("rst_peak", int'(peak_led), 0);
        check("rst_drops", int'(drops), 0);

        // Single load of 170 and full decay
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
        idle(1);
        check("aa_bar", int'(bar), 8'h3F);
        check("aa_peak", int'(peak_led), PEAK_EN ? 8'h20 : 8'h00);
        cnt = 0;
        while (bar != 8'h00 && cnt < 1000) begin
            idle(1);
            cnt++;
        end
        check("aa_decay_cycles", cnt, 680);

        // Smaller byte during decay is ignored
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
        idle(7);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        cnt = 0;
        while (bar == 8'h3F && cnt < 100) begin
            idle(1);
            cnt++;
        end
        check("ignore55_cycles", cnt, 33);
        idle(700);
        check("idle_bar", int'(bar), 0);

        // Rejected bytes and drop saturation
        tick(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
        check("err_drops", int'(drops), 1);
        check("err_bar", int'(bar), 0);
        repeat (300) tick(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
        check("drops_sat", int'(drops), 255);

        // Full scale, peak hold then tracking
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        idle(1);
        check("ff_bar", int'(bar), 8'hFF);
        check("ff_peak", int'(peak_led), PEAK_EN ? 8'h80 : 8'h00);
        cnt = 0;
        while (peak_led != 8'h40 && cnt < 200) begin
            idle(1);
            cnt++;
        end
        check("peak_fall_cycles", cnt, PEAK_EN ? 125 : 200);

        // Disabled load is lost and state frozen
        hb = m_bar; hp = m_pled; hd = 8'(m_drops);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("dis_bar", int'(bar), int'(hb));
        check("dis_peak", int'(peak_led), int'(hp));
        check("dis_drops", int'(drops), int'(hd));

        // Reset wins over a coincident load
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        check("rst_load_bar", int'(bar), 0);
        check("rst_load_peak", int'(peak_led), 0);
        check("rst_load_drops", int'(drops), 0);
        idle(20);
        check("post_rst_bar", int'(bar), 0);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
